rv32i_ctrl_fsm: RTL and testbench
=================================

Name: rv32i_ctrl_fsm

Overview:
- Parametrised multicycle RV32I control unit; the next-generation control FSM for the multicycle datapath.
- Moore FSM that drives every datapath load enable, mux select, ALU/compare op and memory strobe.
- Adds behaviour the base control FSM lacks: memory handshake timeout, sub-word store byte enables, misalignment and illegal-opcode detection, and an optional multi-cycle mul/div wait path.

Parameters:
- ENABLE_MULDIV, 0, 1 = decode OP with funct7=0000001 into the mul/div path; 0 = treat it as illegal.
- TRAP_ON_ILLEGAL, 1, 1 = park in S_HALT on illegal/misaligned; 0 = skip the instruction (PC+4).
- MEM_WAIT_MAX, 0, cycles to wait for mem_resp before timeout; 0 = wait forever. Counter width is $clog2(MEM_WAIT_MAX+1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- br_en  in  1  comparator result
- addr_lsb  in  2  ALU output [1:0] (effective address)
- mem_resp  in  1  memory completion
- md_done  in  1  mul/div unit result valid
- load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out  out  1 each  datapath register enables
- pcmux_sel  out  2  pc_plus4 / alu_out / alu_mod2
- alumux1_sel  out  1  rs1 / pc
- alumux2_sel  out  3  i_imm / u_imm / b_imm / s_imm / j_imm / rs2
- regfilemux_sel  out  4  alu / br_en / u_imm / lw / pc+4 / lb / lbu / lh / lhu / md_out
- marmux_sel  out  1  pc / alu_out
- cmpmux_sel  out  1  rs2 / i_imm
- aluop  out  3  rv32i ALU op
- cmpop  out  3  branch funct3
- mem_read, mem_write  out  1 each  memory strobes
- mem_byte_enable  out  4  store lane mask
- md_start  out  1  one-cycle mul/div start
- fault  out  1  high while in S_HALT
- mem_timeout  out  1  one-cycle pulse on memory timeout

Behaviour:
- Outputs are combinational from the registered state, plus mem_resp/md_done qualification. Default for every output is 0.
- Reset:
  - While rst=1, all outputs are forced to 0.
  - State becomes S_FETCH1 and the wait counter clears on the next edge.
  - Reset mid-operation aborts the instruction immediately, including an in-flight memory access.
- S_FETCH1: load_mar=1, marmux=pc. Go to S_FETCH2.
- S_FETCH2: mem_read=1, load_mdr=mem_resp. On mem_resp go to S_FETCH3, else stay.
- S_FETCH3: load_ir=1. Go to S_DECODE.
- S_DECODE: no outputs. Branch on opcode:
  - LUI -> S_LUI, AUIPC -> S_AUIPC, JAL -> S_JAL, JALR -> S_JALR
  - BR -> S_BR, LOAD/STORE -> S_CALC_ADDR, IMM -> S_IMM
  - REG -> S_REG, or S_MD1 when ENABLE_MULDIV and funct7=0000001
  - anything else -> illegal.
- Illegal handling: S_HALT if TRAP_ON_ILLEGAL, else S_SKIP.
- S_SKIP: load_pc, pcmux=pc_plus4. Go to S_FETCH1.
- Execute states each take one cycle, assert load_pc, and go to S_FETCH1:
  - S_IMM: SLTI/SLTIU use cmpmux=i_imm, regfilemux=br_en. SRAI uses aluop=sra when funct7[5]=1.
  - S_REG: SUB/SRA selected by funct7[5].
  - S_BR: pcmux=alu_out only if br_en.
  - S_JAL / S_JALR: regfilemux=pc+4. JALR uses pcmux=alu_mod2.
- S_CALC_ADDR: load_mar=1, marmux=alu_out, and load_data_out for stores.
  - Misaligned access (LH/LHU/SH with addr_lsb[0]=1; LW/SW with addr_lsb!=0) is treated as illegal.
  - Otherwise go to S_LD1 or S_ST1.
- S_LD1: mem_read=1, load_mdr=mem_resp. Advance on mem_resp.
- S_LD2: load_regfile, regfilemux chosen by funct3, load_pc.
- S_ST1: mem_write=1. Advance on mem_resp. Byte enables:
  - SB: 0001<<addr_lsb
  - SH: 0011<<{addr_lsb[1],0}
  - SW: 1111
  - Reads always use 1111.
- S_ST2: load_pc.
- Mul/div path:
  - S_MD1: md_start=1 for exactly one cycle. Go to S_MD2.
  - S_MD2: wait for md_done; then load_regfile (regfilemux=md_out), load_pc.
  - md_done that arrives in S_MD1 is ignored.
- Memory wait:
  - mem_resp in the first cycle of the strobe is legal (zero-wait).
  - mem_resp outside S_FETCH2/S_LD1/S_ST1 is ignored.
  - The counter increments each cycle in those states and clears on exit.
  - If MEM_WAIT_MAX>0 and the counter reaches MEM_WAIT_MAX with no mem_resp: pulse mem_timeout, drop the strobe, enter S_HALT.
  - mem_resp arriving in the same cycle the counter reaches the limit wins; no timeout.
- S_HALT: fault=1. Exit only via rst.

Decomposition:
- Package rv32i_types holds opcode/funct3 enums plus the pcmux/alumux/regfilemux/aluop typedefs.
- The state enum stays local to the module.
- One sub-module, rv32i_mem_align: combinational misalign check and byte-enable generation from funct3/addr_lsb/is_store.

Test Plan:
- Reset with ADDI x1,x0,5 fetched, mem_resp after 2 cycles: FETCH2 held 3 cycles; at S_IMM load_regfile=1, aluop=add, alumux2=i_imm; back in S_FETCH1 7 cycles after reset release.
- SB with addr_lsb=2'b10: mem_byte_enable=0100 in S_ST1. SH with addr_lsb=2'b10: 1100. SW with addr_lsb=2'b01: S_HALT, fault=1.
- BEQ with br_en=0: pcmux=pc_plus4. With br_en=1: pcmux=alu_out.
- MEM_WAIT_MAX=4, mem_resp never asserted: mem_timeout pulses in the 4th S_FETCH2 cycle, then S_HALT. A repeat with mem_resp on that 4th cycle: no timeout.
- ENABLE_MULDIV=1, MUL, md_done after 6 cycles: md_start high exactly 1 cycle, then load_regfile with regfilemux=md_out. ENABLE_MULDIV=0 with TRAP_ON_ILLEGAL=0: S_SKIP, PC+4.
- rst asserted during S_LD1: all outputs 0 that cycle, S_FETCH1 next; a late mem_resp is ignored.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I encodings and datapath select types for the multicycle control unit.
// Select encodings follow the datapath mux port order.
package rv32i_types;

  typedef enum logic [6:0] {
    OP_LUI   = 7'b0110111,
    OP_AUIPC = 7'b0010111,
    OP_JAL   = 7'b1101111,
    OP_JALR  = 7'b1100111,
    OP_BR    = 7'b1100011,
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_IMM   = 7'b0010011,
    OP_REG   = 7'b0110011
  } rv32i_opcode_e;

  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } arith_funct3_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_e;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_funct3_e;

  typedef enum logic [1:0] {
    PCMUX_PC_PLUS4 = 2'd0,
    PCMUX_ALU_OUT  = 2'd1,
    PCMUX_ALU_MOD2 = 2'd2
  } pcmux_sel_e;

  typedef enum logic {
    ALUMUX1_RS1 = 1'b0,
    ALUMUX1_PC  = 1'b1
  } alumux1_sel_e;

  typedef enum logic [2:0] {
    ALUMUX2_I_IMM = 3'd0,
    ALUMUX2_U_IMM = 3'd1,
    ALUMUX2_B_IMM = 3'd2,
    ALUMUX2_S_IMM = 3'd3,
    ALUMUX2_J_IMM = 3'd4,
    ALUMUX2_RS2   = 3'd5
  } alumux2_sel_e;

  typedef enum logic [3:0] {
    RFMUX_ALU      = 4'd0,
    RFMUX_BR_EN    = 4'd1,
    RFMUX_U_IMM    = 4'd2,
    RFMUX_LW       = 4'd3,
    RFMUX_PC_PLUS4 = 4'd4,
    RFMUX_LB       = 4'd5,
    RFMUX_LBU      = 4'd6,
    RFMUX_LH       = 4'd7,
    RFMUX_LHU      = 4'd8,
    RFMUX_MD_OUT   = 4'd9
  } regfilemux_sel_e;

  typedef enum logic {
    MARMUX_PC      = 1'b0,
    MARMUX_ALU_OUT = 1'b1
  } marmux_sel_e;

  typedef enum logic {
    CMPMUX_RS2   = 1'b0,
    CMPMUX_I_IMM = 1'b1
  } cmpmux_sel_e;

  // Chosen so the arithmetic funct3 values map straight onto the ALU op.
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SLL = 3'b001,
    ALU_SRA = 3'b010,
    ALU_SUB = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SRL = 3'b101,
    ALU_OR  = 3'b110,
    ALU_AND = 3'b111
  } alu_ops_e;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/rv32i_mem_align.sv
// Combinational alignment check and store lane mask for RV32I loads/stores.
module rv32i_mem_align
  import rv32i_types::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lsb,
  input  logic       is_store,
  output logic       misaligned,
  output logic [3:0] byte_enable
);

  // funct3[2] only selects sign extension, so the access size is funct3[1:0].
  always_comb begin
    misaligned  = 1'b0;
    byte_enable = is_store ? 4'b0000 : 4'b1111;
    case (funct3[1:0])
      SIZE_BYTE: begin
        if (is_store) byte_enable = 4'b0001 << addr_lsb;
      end
      SIZE_HALF: begin
        misaligned = addr_lsb[0];
        if (is_store) byte_enable = 4'b0011 << {addr_lsb[1], 1'b0};
      end
      SIZE_WORD: begin
        misaligned = |addr_lsb;
        if (is_store) byte_enable = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32i_ctrl_fsm.sv
// Multicycle RV32I control FSM: Moore outputs from state, qualified by mem_resp/md_done,
// with memory timeout, misalign/illegal trapping and an optional mul/div wait path.
module rv32i_ctrl_fsm
  import rv32i_types::*;
#(
  parameter bit          ENABLE_MULDIV   = 1'b0,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1,
  parameter int unsigned MEM_WAIT_MAX    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       br_en,
  input  logic [1:0] addr_lsb,
  input  logic       mem_resp,
  input  logic       md_done,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_regfile,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_data_out,
  output logic [1:0] pcmux_sel,
  output logic       alumux1_sel,
  output logic [2:0] alumux2_sel,
  output logic [3:0] regfilemux_sel,
  output logic       marmux_sel,
  output logic       cmpmux_sel,
  output logic [2:0] aluop,
  output logic [2:0] cmpop,
  output logic       mem_read,
  output logic       mem_write,
  output logic [3:0] mem_byte_enable,
  output logic       md_start,
  output logic       fault,
  output logic       mem_timeout
);

  typedef enum logic [4:0] {
    S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
    S_LUI, S_AUIPC, S_JAL, S_JALR, S_BR, S_IMM, S_REG,
    S_CALC_ADDR, S_LD1, S_LD2, S_ST1, S_ST2,
    S_MD1, S_MD2, S_SKIP, S_HALT
  } state_e;

  localparam int CNT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

  state_e           state, state_next, illegal_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_wait_state, wait_expired;
  logic             is_store, misaligned;
  logic [3:0]       store_be;

  pcmux_sel_e      pcmux;
  alumux1_sel_e    alumux1;
  alumux2_sel_e    alumux2;
  regfilemux_sel_e regfilemux;
  marmux_sel_e     marmux;
  cmpmux_sel_e     cmpmux;
  alu_ops_e        alu_op;
  branch_funct3_e  cmp_op;

  assign illegal_state  = TRAP_ON_ILLEGAL ? S_HALT : S_SKIP;
  assign is_store       = (opcode == OP_STORE);
  assign mem_wait_state = (state == S_FETCH2) || (state == S_LD1) || (state == S_ST1);
  // Fires on the MEM_WAIT_MAX-th strobe cycle; a response in that same cycle wins.
  assign wait_expired   = (MEM_WAIT_MAX > 0) && mem_wait_state && !mem_resp &&
                          (wait_cnt == CNT_W'(MEM_WAIT_MAX - 1));

  rv32i_mem_align u_mem_align (
    .funct3      (funct3),
    .addr_lsb    (addr_lsb),
    .is_store    (is_store),
    .misaligned  (misaligned),
    .byte_enable (store_be)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state    <= S_FETCH1;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if ((MEM_WAIT_MAX > 0) && mem_wait_state && (state_next == state)) wait_cnt <= wait_cnt + 1'b1;
      else wait_cnt <= '0;
    end
  end

  always_comb begin
    // NOTE: every output and the next state get a default first so no path infers a latch.
    state_next      = state;
    load_pc         = 1'b0;
    load_ir         = 1'b0;
    load_regfile    = 1'b0;
    load_mar        = 1'b0;
    load_mdr        = 1'b0;
    load_data_out   = 1'b0;
    pcmux           = PCMUX_PC_PLUS4;
    alumux1         = ALUMUX1_RS1;
    alumux2         = ALUMUX2_I_IMM;
    regfilemux      = RFMUX_ALU;
    marmux          = MARMUX_PC;
    cmpmux          = CMPMUX_RS2;
    alu_op          = ALU_ADD;
    cmp_op          = F3_BEQ;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 4'b0000;
    md_start        = 1'b0;
    fault           = 1'b0;
    mem_timeout     = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH1: begin
          load_mar   = 1'b1;
          marmux     = MARMUX_PC;
          state_next = S_FETCH2;
        end
        S_FETCH2: begin
          if (wait_expired) begin
            mem_timeout = 1'b1;
            state_next  = S_HALT;
          end else begin
            mem_read        = 1'b1;
            mem_byte_enable = 4'b1111;
            load_mdr        = mem_resp;
            if (mem_resp) state_next = S_FETCH3;
          end
        end
        S_FETCH3: begin
          load_ir    = 1'b1;
          state_next = S_DECODE;
        end
        S_DECODE: begin
          case (opcode)
            OP_LUI:   state_next = S_LUI;
            OP_AUIPC: state_next = S_AUIPC;
            OP_JAL:   state_next = S_JAL;
            OP_JALR:  state_next = S_JALR;
            OP_BR:    state_next = S_BR;
            OP_LOAD,
            OP_STORE: state_next = S_CALC_ADDR;
            OP_IMM:   state_next = S_IMM;
            OP_REG: begin
              if (funct7 != FUNCT7_MULDIV) state_next = S_REG;
              else if (ENABLE_MULDIV)      state_next = S_MD1;
              else                         state_next = illegal_state;
            end
            default:  state_next = illegal_state;
          endcase
        end
        S_LUI: begin
          load_regfile = 1'b1;
          regfilemux   = RFMUX_U_IMM;
          load_pc      = 1'b1;
          state_next   = S_FETCH1;
        end
        S_AUIPC: begin
          alumux1      = ALUMUX1_PC;
          alumux2      = ALUMUX2_U_IMM;
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          state_next   = S_FETCH1;
        end
        S_JAL: begin
          alumux1      = ALUMUX1_PC;
          alumux2      = ALUMUX2_J_IMM;
          pcmux        = PCMUX_ALU_OUT;
          regfilemux   = RFMUX_PC_PLUS4;
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          state_next   = S_FETCH1;
        end
        S_JALR: begin
          alumux2      = ALUMUX2_I_IMM;
          pcmux        = PCMUX_ALU_MOD2;
          regfilemux   = RFMUX_PC_PLUS4;
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          state_next   = S_FETCH1;
        end
        S_BR: begin
          alumux1    = ALUMUX1_PC;
          alumux2    = ALUMUX2_B_IMM;
          cmp_op     = branch_funct3_e'(funct3);
          pcmux      = br_en ? PCMUX_ALU_OUT : PCMUX_PC_PLUS4;
          load_pc    = 1'b1;
          state_next = S_FETCH1;
        end
        S_IMM: begin
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          state_next   = S_FETCH1;
          case (funct3)
            F3_SLT:  begin cmp_op = F3_BLT;  cmpmux = CMPMUX_I_IMM; regfilemux = RFMUX_BR_EN; end
            F3_SLTU: begin cmp_op = F3_BLTU; cmpmux = CMPMUX_I_IMM; regfilemux = RFMUX_BR_EN; end
            F3_SR:   alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
            default: alu_op = alu_ops_e'(funct3);
          endcase
        end
        S_REG: begin
          alumux2      = ALUMUX2_RS2;
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          state_next   = S_FETCH1;
          case (funct3)
            F3_ADD:  alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
            F3_SLT:  begin cmp_op = F3_BLT;  regfilemux = RFMUX_BR_EN; end
            F3_SLTU: begin cmp_op = F3_BLTU; regfilemux = RFMUX_BR_EN; end
            F3_SR:   alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
            default: alu_op = alu_ops_e'(funct3);
          endcase
        end
        S_CALC_ADDR: begin
          alumux2       = is_store ? ALUMUX2_S_IMM : ALUMUX2_I_IMM;
          load_mar      = 1'b1;
          marmux        = MARMUX_ALU_OUT;
          load_data_out = is_store;
          if (misaligned)    state_next = illegal_state;
          else if (is_store) state_next = S_ST1;
          else               state_next = S_LD1;
        end
        S_LD1: begin
          if (wait_expired) begin
            mem_timeout = 1'b1;
            state_next  = S_HALT;
          end else begin
            mem_read        = 1'b1;
            mem_byte_enable = 4'b1111;
            load_mdr        = mem_resp;
            if (mem_resp) state_next = S_LD2;
          end
        end
        S_LD2: begin
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          state_next   = S_FETCH1;
          case (funct3)
            F3_LB:   regfilemux = RFMUX_LB;
            F3_LBU:  regfilemux = RFMUX_LBU;
            F3_LH:   regfilemux = RFMUX_LH;
            F3_LHU:  regfilemux = RFMUX_LHU;
            default: regfilemux = RFMUX_LW;
          endcase
        end
        S_ST1: begin
          if (wait_expired) begin
            mem_timeout = 1'b1;
            state_next  = S_HALT;
          end else begin
            mem_write       = 1'b1;
            mem_byte_enable = store_be;
            if (mem_resp) state_next = S_ST2;
          end
        end
        S_ST2: begin
          load_pc    = 1'b1;
          state_next = S_FETCH1;
        end
        S_MD1: begin
          md_start   = 1'b1;
          state_next = S_MD2;
        end
        S_MD2: begin
          if (md_done) begin
            load_regfile = 1'b1;
            regfilemux   = RFMUX_MD_OUT;
            load_pc      = 1'b1;
            state_next   = S_FETCH1;
          end
        end
        S_SKIP: begin
          load_pc    = 1'b1;
          pcmux      = PCMUX_PC_PLUS4;
          state_next = S_FETCH1;
        end
        S_HALT: fault = 1'b1;
        default: state_next = S_FETCH1;
      endcase
    end
  end

  assign pcmux_sel      = pcmux;
  assign alumux1_sel    = alumux1;
  assign alumux2_sel    = alumux2;
  assign regfilemux_sel = regfilemux;
  assign marmux_sel     = marmux;
  assign cmpmux_sel     = cmpmux;
  assign aluop          = alu_op;
  assign cmpop          = cmp_op;

endmodule

// File: tb/tb_rv32i_ctrl_fsm.sv
// Directed scoreboard bench for rv32i_ctrl_fsm: one instance with mul/div, trapping and
// a 4-cycle memory timeout, one with mul/div off, skip-on-illegal and no timeout.
module tb_rv32i_ctrl_fsm;

  typedef struct packed {
    logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
    logic [1:0] pcmux_sel;
    logic       alumux1_sel;
    logic [2:0] alumux2_sel;
    logic [3:0] regfilemux_sel;
    logic       marmux_sel, cmpmux_sel;
    logic [2:0] aluop, cmpop;
    logic       mem_read, mem_write;
    logic [3:0] mem_byte_enable;
    logic       md_start, fault, mem_timeout;
  } ctrl_t;

  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_REG   = 7'b0110011;
  localparam bit DUT_A = 1'b0;
  localparam bit DUT_B = 1'b1;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       br_en, mem_resp, md_done;
  logic [1:0] addr_lsb;
  wire ctrl_t oa, ob;

  int    checks = 0;
  int    errors = 0;
  ctrl_t sb_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  rv32i_ctrl_fsm #(.ENABLE_MULDIV(1'b1), .TRAP_ON_ILLEGAL(1'b1), .MEM_WAIT_MAX(4)) dut_a (
    .clk(clk), .rst(rst_a), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .br_en(br_en), .addr_lsb(addr_lsb), .mem_resp(mem_resp), .md_done(md_done),
    .load_pc(oa.load_pc), .load_ir(oa.load_ir), .load_regfile(oa.load_regfile),
    .load_mar(oa.load_mar), .load_mdr(oa.load_mdr), .load_data_out(oa.load_data_out),
    .pcmux_sel(oa.pcmux_sel), .alumux1_sel(oa.alumux1_sel), .alumux2_sel(oa.alumux2_sel),
    .regfilemux_sel(oa.regfilemux_sel), .marmux_sel(oa.marmux_sel), .cmpmux_sel(oa.cmpmux_sel),
    .aluop(oa.aluop), .cmpop(oa.cmpop), .mem_read(oa.mem_read), .mem_write(oa.mem_write),
    .mem_byte_enable(oa.mem_byte_enable), .md_start(oa.md_start), .fault(oa.fault),
    .mem_timeout(oa.mem_timeout)
  );

  rv32i_ctrl_fsm #(.ENABLE_MULDIV(1'b0), .TRAP_ON_ILLEGAL(1'b0), .MEM_WAIT_MAX(0)) dut_b (
    .clk(clk), .rst(rst_b), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .br_en(br_en), .addr_lsb(addr_lsb), .mem_resp(mem_resp), .md_done(md_done),
    .load_pc(ob.load_pc), .load_ir(ob.load_ir), .load_regfile(ob.load_regfile),
    .load_mar(ob.load_mar), .load_mdr(ob.load_mdr), .load_data_out(ob.load_data_out),
    .pcmux_sel(ob.pcmux_sel), .alumux1_sel(ob.alumux1_sel), .alumux2_sel(ob.alumux2_sel),
    .regfilemux_sel(ob.regfilemux_sel), .marmux_sel(ob.marmux_sel), .cmpmux_sel(ob.cmpmux_sel),
    .aluop(ob.aluop), .cmpop(ob.cmpop), .mem_read(ob.mem_read), .mem_write(ob.mem_write),
    .mem_byte_enable(ob.mem_byte_enable), .md_start(ob.md_start), .fault(ob.fault),
    .mem_timeout(ob.mem_timeout)
  );

  // Expected control words
  function automatic ctrl_t x_f1();
    ctrl_t e = '0;
    e.load_mar = 1'b1;
    return e;
  endfunction

  function automatic ctrl_t x_rd(input logic resp);
    ctrl_t e = '0;
    e.mem_read = 1'b1;
    e.mem_byte_enable = 4'b1111;
    e.load_mdr = resp;
    return e;
  endfunction

  function automatic ctrl_t x_f3();
    ctrl_t e = '0;
    e.load_ir = 1'b1;
    return e;
  endfunction

  function automatic ctrl_t x_pc();
    ctrl_t e = '0;
    e.load_pc = 1'b1;
    return e;
  endfunction

  function automatic ctrl_t x_wb(input logic [3:0] rfmux);
    ctrl_t e = '0;
    e.load_pc = 1'b1;
    e.load_regfile = 1'b1;
    e.regfilemux_sel = rfmux;
    return e;
  endfunction

  function automatic ctrl_t x_calc(input logic store);
    ctrl_t e = '0;
    e.load_mar = 1'b1;
    e.marmux_sel = 1'b1;
    e.alumux2_sel = store ? 3'd3 : 3'd0;
    e.load_data_out = store;
    return e;
  endfunction

  function automatic ctrl_t x_st1(input logic [3:0] be);
    ctrl_t e = '0;
    e.mem_write = 1'b1;
    e.mem_byte_enable = be;
    return e;
  endfunction

  function automatic ctrl_t x_br(input logic taken);
    ctrl_t e = '0;
    e.load_pc = 1'b1;
    e.alumux1_sel = 1'b1;
    e.alumux2_sel = 3'd2;
    e.cmpop = 3'b000;
    e.pcmux_sel = taken ? 2'd1 : 2'd0;
    return e;
  endfunction

  function automatic ctrl_t x_halt();
    ctrl_t e = '0;
    e.fault = 1'b1;
    return e;
  endfunction

  // Push the expectation, then compare at the falling edge and advance one cycle.
  task automatic step(input bit use_b, input ctrl_t exp, input string tag);
    ctrl_t obs, want;
    string t;
    sb_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    obs  = use_b ? ob : oa;
    want = sb_q.pop_front();
    t    = tag_q.pop_front();
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, obs, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input bit use_b, input string tag);
    mem_resp = 1'b0;
    step(use_b, x_f1(), {tag, "_f1"});
    mem_resp = 1'b1;
    step(use_b, x_rd(1'b1), {tag, "_f2"});
    mem_resp = 1'b0;
    step(use_b, x_f3(), {tag, "_f3"});
    step(use_b, '0, {tag, "_dec"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ctrl_t e;
    rst_a = 1'b1; rst_b = 1'b1;
    opcode = OPC_IMM; funct3 = 3'b000; funct7 = 7'b0;
    br_en = 1'b0; addr_lsb = 2'b00; mem_resp = 1'b1; md_done = 1'b0;

    // ADDI with a two-cycle memory wait on the fetch
    step(DUT_A, '0, "rst_outputs_zero");
    rst_a = 1'b0; mem_resp = 1'b0;
    step(DUT_A, x_f1(), "addi_f1");
    step(DUT_A, x_rd(1'b0), "addi_f2_wait1");
    step(DUT_A, x_rd(1'b0), "addi_f2_wait2");
    mem_resp = 1'b1;
    step(DUT_A, x_rd(1'b1), "addi_f2_resp");
    mem_resp = 1'b0;
    step(DUT_A, x_f3(), "addi_f3");
    step(DUT_A, '0, "addi_dec");
    step(DUT_A, x_wb(4'd0), "addi_exec");

    // SB, lane 2
    opcode = OPC_STORE; funct3 = 3'b000; addr_lsb = 2'b10;
    fetch(DUT_A, "sb");
    step(DUT_A, x_calc(1'b1), "sb_calc");
    step(DUT_A, x_st1(4'b0100), "sb_st1_wait");
    mem_resp = 1'b1;
    step(DUT_A, x_st1(4'b0100), "sb_st1_resp");
    mem_resp = 1'b0;
    step(DUT_A, x_pc(), "sb_st2");

    // SH, upper half
    funct3 = 3'b001;
    fetch(DUT_A, "sh");
    step(DUT_A, x_calc(1'b1), "sh_calc");
    mem_resp = 1'b1;
    step(DUT_A, x_st1(4'b1100), "sh_st1");
    mem_resp = 1'b0;
    step(DUT_A, x_pc(), "sh_st2");

    // SW misaligned traps; only reset leaves S_HALT
    funct3 = 3'b010; addr_lsb = 2'b01;
    fetch(DUT_A, "sw");
    step(DUT_A, x_calc(1'b1), "sw_calc");
    step(DUT_A, x_halt(), "sw_halt");
    mem_resp = 1'b1;
    step(DUT_A, x_halt(), "sw_halt_hold");
    mem_resp = 1'b0; rst_a = 1'b1;
    step(DUT_A, '0, "halt_rst");
    rst_a = 1'b0; addr_lsb = 2'b00;

    // BEQ not taken, then taken
    opcode = OPC_BR; funct3 = 3'b000;
    fetch(DUT_A, "beq_nt");
    br_en = 1'b0;
    step(DUT_A, x_br(1'b0), "beq_not_taken");
    fetch(DUT_A, "beq_t");
    br_en = 1'b1;
    step(DUT_A, x_br(1'b1), "beq_taken");
    br_en = 1'b0;

    // Fetch timeout after four silent cycles
    opcode = OPC_REG; funct7 = 7'b0000001; funct3 = 3'b000;
    step(DUT_A, x_f1(), "to_f1");
    for (int i = 0; i < 3; i++) step(DUT_A, x_rd(1'b0), "to_f2_wait");
    e = '0; e.mem_timeout = 1'b1;
    step(DUT_A, e, "to_pulse");
    step(DUT_A, x_halt(), "to_halt");
    rst_a = 1'b1;
    step(DUT_A, '0, "to_rst");
    rst_a = 1'b0;

    // Response on the limit cycle wins, then MUL through the mul/div path
    step(DUT_A, x_f1(), "resp_win_f1");
    for (int i = 0; i < 3; i++) step(DUT_A, x_rd(1'b0), "resp_win_wait");
    mem_resp = 1'b1;
    step(DUT_A, x_rd(1'b1), "resp_win_no_timeout");
    mem_resp = 1'b0;
    step(DUT_A, x_f3(), "mul_f3");
    step(DUT_A, '0, "mul_dec");
    md_done = 1'b1;
    e = '0; e.md_start = 1'b1;
    step(DUT_A, e, "mul_md1_start");
    md_done = 1'b0;
    for (int i = 0; i < 4; i++) step(DUT_A, '0, "mul_md2_wait");
    md_done = 1'b1;
    step(DUT_A, x_wb(4'd9), "mul_md2_done");
    md_done = 1'b0;

    // SRAI picks arithmetic shift from funct7[5]
    opcode = OPC_IMM; funct3 = 3'b101; funct7 = 7'b0100000;
    fetch(DUT_A, "srai");
    e = x_wb(4'd0); e.aluop = 3'b010;
    step(DUT_A, e, "srai_exec");

    // Second instance: long wait without timeout, MUL skipped as illegal
    rst_a = 1'b1; rst_b = 1'b1;
    opcode = OPC_REG; funct3 = 3'b000; funct7 = 7'b0000001;
    step(DUT_B, '0, "b_rst");
    rst_b = 1'b0;
    step(DUT_B, x_f1(), "b_f1");
    for (int i = 0; i < 6; i++) step(DUT_B, x_rd(1'b0), "b_f2_no_limit");
    mem_resp = 1'b1;
    step(DUT_B, x_rd(1'b1), "b_f2_resp");
    mem_resp = 1'b0;
    step(DUT_B, x_f3(), "b_f3");
    step(DUT_B, '0, "b_dec");
    step(DUT_B, x_pc(), "b_mul_skip");

    // SUB
    funct7 = 7'b0100000;
    fetch(DUT_B, "sub");
    e = x_wb(4'd0); e.alumux2_sel = 3'd5; e.aluop = 3'b011;
    step(DUT_B, e, "sub_exec");

    // LH completes with the halfword writeback select
    opcode = OPC_LOAD; funct3 = 3'b001; funct7 = 7'b0; addr_lsb = 2'b10;
    fetch(DUT_B, "lh");
    step(DUT_B, x_calc(1'b0), "lh_calc");
    mem_resp = 1'b1;
    step(DUT_B, x_rd(1'b1), "lh_ld1");
    mem_resp = 1'b0;
    step(DUT_B, x_wb(4'd7), "lh_ld2");

    // LW aborted by reset in S_LD1; a late response is ignored
    funct3 = 3'b010; addr_lsb = 2'b00;
    fetch(DUT_B, "lw");
    step(DUT_B, x_calc(1'b0), "lw_calc");
    step(DUT_B, x_rd(1'b0), "lw_ld1_wait");
    rst_b = 1'b1;
    step(DUT_B, '0, "lw_rst_abort");
    rst_b = 1'b0; mem_resp = 1'b1;
    step(DUT_B, x_f1(), "lw_late_resp_ignored");
    mem_resp = 1'b0;
    step(DUT_B, x_rd(1'b0), "lw_refetch_wait");

    // SLTI through the comparator
    opcode = OPC_IMM; funct3 = 3'b010;
    mem_resp = 1'b1;
    step(DUT_B, x_rd(1'b1), "slti_f2");
    mem_resp = 1'b0;
    step(DUT_B, x_f3(), "slti_f3");
    step(DUT_B, '0, "slti_dec");
    e = x_wb(4'd1); e.cmpop = 3'b100; e.cmpmux_sel = 1'b1;
    step(DUT_B, e, "slti_exec");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
